// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte producers.
// Latches the winner's byte, pulses start, and tracks tx busy with a start timeout.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned DBIT         = 8,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*DBIT-1:0]    i_data,
    output logic [NREQ-1:0]         o_ack,
    output logic                    o_tx_start,
    output logic [DBIT-1:0]         o_tx_data,
    input  logic                    i_tx_busy,
    output logic [$clog2(NREQ)-1:0] o_active_id,
    output logic                    o_busy,
    output logic                    o_err
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DBIT-1:0] data_q, data_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;

    logic [DBIT-1:0] req_bytes [NREQ];
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  scan_idx;
    logic            found;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return IDW'((32'(id) + 1) % NREQ);
    endfunction

    for (genvar k = 0; k < NREQ; k++) begin : g_bytes
        assign req_bytes[k] = i_data[k*DBIT +: DBIT];
    end

    // First requester at or above the rr pointer, wrapping modulo NREQ.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = IDW'((32'(rr_q) + i) % NREQ);
            if (!found && i_req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        id_d    = id_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!i_tx_busy && found) begin
                    data_d  = req_bytes[winner];
                    id_d    = winner;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (i_tx_busy) begin
                    ack_d[id_q] = 1'b1;
                    state_d     = StWaitDone;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never took the byte: give up without an ack.
                    err_d   = 1'b1;
                    rr_d    = next_id(id_q);
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!i_tx_busy) begin
                    rr_d    = next_id(id_q);
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_tx_start  = start_q;
    assign o_tx_data   = data_q;
    assign o_active_id = id_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a scoreboard of expected grants
// is filled when requests are driven and drained at each start pulse.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ         = 4;
    localparam int unsigned DBIT         = 8;
    localparam int unsigned BUSY_TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] data;
    logic [NREQ-1:0]      ack;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_data;
    logic                 tx_busy;
    logic [1:0]           active_id;
    logic                 busy;
    logic                 err;

    logic model_en;
    logic model_rise;
    logic model_busy;
    logic man_busy;
    int   n_checks;
    int   n_pass;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q[$];

    assign tx_busy = model_en ? model_busy : man_busy;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .DBIT(DBIT),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req(req),
        .i_data(data),
        .o_ack(ack),
        .o_tx_start(tx_start),
        .o_tx_data(tx_data),
        .i_tx_busy(tx_busy),
        .o_active_id(active_id),
        .o_busy(busy),
        .o_err(err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises 2 cycles after the start pulse, lasts 10 cycles.
    initial model_busy = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (model_en && model_rise && tx_start) begin
            @(posedge clk);
            #2 model_busy = 1'b1;
            repeat (10) @(posedge clk);
            #2 model_busy = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy === 1'b0 && tx_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Finish a frame by hand after the start pulse has been sampled.
    task automatic manual_finish();
        req      = '0;
        man_busy = 1'b1;
        tick();
        tick();
        man_busy = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        req        = '0;
        data       = '0;
        man_busy   = 1'b0;
        model_en   = 1'b0;
        model_rise = 1'b1;
        do_reset();
        n_checks++;
        if ({ack, tx_start, tx_data, active_id, busy, err} !== '0)
            $display("FAIL reset_outputs: actual ack=%b start=%b data=%h id=%0d busy=%b err=%b, required all 0",
                     ack, tx_start, tx_data, active_id, busy, err);
        else n_pass++;
        tick();
        n_checks++;
        if (tx_start !== 1'b0) $display("FAIL reset_idle_start: actual %b, required 0", tx_start);
        else n_pass++;
    endtask

    task automatic test_single();
        exp_t e;
        int   cnt;
        model_en   = 1'b1;
        model_rise = 1'b1;
        do_reset();
        data = {8'h33, 8'hA5, 8'h11, 8'h00};
        req  = 4'b0100;
        sb_q.push_back('{id: 2'd2, data: 8'hA5});
        tick();
        n_checks++;
        if (tx_start !== 1'b1) $display("FAIL single_start_latency: actual %b, required 1", tx_start);
        else n_pass++;
        e = sb_q.pop_front();
        n_checks++;
        if ({active_id, tx_data, busy} !== {e.id, e.data, 1'b1})
            $display("FAIL single_grant: actual id=%0d data=%h busy=%b, required id=%0d data=%h busy=1",
                     active_id, tx_data, busy, e.id, e.data);
        else n_pass++;
        req = '0;
        tick();
        n_checks++;
        if (tx_start !== 1'b0) $display("FAIL single_start_width: actual %b, required 0", tx_start);
        else n_pass++;
        tick();
        n_checks++;
        if (ack !== 4'b0100 || err !== 1'b0)
            $display("FAIL single_ack: actual ack=%b err=%b, required ack=0100 err=0", ack, err);
        else n_pass++;
        tick();
        n_checks++;
        if (ack !== 4'b0000) $display("FAIL single_ack_width: actual %b, required 0000", ack);
        else n_pass++;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt !== 9) $display("FAIL single_busy_fall: actual %0d cycles, required 9", cnt);
        else n_pass++;
    endtask

    task automatic test_all_rr();
        exp_t e;
        bit   seen;
        bit   ok;
        model_en   = 1'b1;
        model_rise = 1'b1;
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        req  = 4'b1111;
        do_reset();
        sb_q.push_back('{id: 2'd0, data: 8'h10});
        sb_q.push_back('{id: 2'd1, data: 8'h11});
        sb_q.push_back('{id: 2'd2, data: 8'h12});
        sb_q.push_back('{id: 2'd3, data: 8'h13});
        sb_q.push_back('{id: 2'd0, data: 8'h10});
        for (int k = 0; k < 5; k++) begin
            wait_start(60, seen);
            n_checks++;
            if (seen !== 1'b1) $display("FAIL rr_start%0d: actual no start, required start", k);
            else begin
                n_pass++;
                e = sb_q.pop_front();
                n_checks++;
                if ({active_id, tx_data} !== {e.id, e.data})
                    $display("FAIL rr_grant%0d: actual id=%0d data=%h, required id=%0d data=%h",
                             k, active_id, tx_data, e.id, e.data);
                else n_pass++;
            end
        end
        req = '0;
        sb_q.delete();
        wait_idle(60, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL rr_idle: actual busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_alternate();
        exp_t e;
        bit   seen;
        bit   ok;
        model_en   = 1'b1;
        model_rise = 1'b1;
        data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req  = 4'b0101;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb_q.push_back('{id: 2'd0, data: 8'hA0});
            else            sb_q.push_back('{id: 2'd2, data: 8'hC2});
        end
        for (int k = 0; k < 4; k++) begin
            wait_start(60, seen);
            n_checks++;
            if (seen !== 1'b1) $display("FAIL alt_start%0d: actual no start, required start", k);
            else begin
                n_pass++;
                e = sb_q.pop_front();
                n_checks++;
                if ({active_id, tx_data} !== {e.id, e.data})
                    $display("FAIL alt_grant%0d: actual id=%0d data=%h, required id=%0d data=%h",
                             k, active_id, tx_data, e.id, e.data);
                else n_pass++;
            end
        end
        req = '0;
        sb_q.delete();
        wait_idle(60, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL alt_idle: actual busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   seen;
        bit   ok;
        bit   ack_seen;
        int   err_at;
        model_en   = 1'b1;
        model_rise = 1'b0;
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = 4'b0011;
        do_reset();
        sb_q.push_back('{id: 2'd0, data: 8'h11});
        sb_q.push_back('{id: 2'd1, data: 8'h22});
        wait_start(10, seen);
        n_checks++;
        if (seen !== 1'b1) $display("FAIL to_start: actual no start, required start");
        else n_pass++;
        e = sb_q.pop_front();
        n_checks++;
        if ({active_id, tx_data} !== {e.id, e.data})
            $display("FAIL to_grant0: actual id=%0d data=%h, required id=%0d data=%h",
                     active_id, tx_data, e.id, e.data);
        else n_pass++;
        ack_seen = 1'b0;
        err_at   = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ack !== '0) ack_seen = 1'b1;
            if (err === 1'b1) begin
                err_at = i;
                break;
            end
        end
        // Start sample, one edge into WAIT_BUSY, then BUSY_TIMEOUT edges.
        n_checks++;
        if (err_at !== 17) $display("FAIL to_err_time: actual %0d, required 17", err_at);
        else n_pass++;
        n_checks++;
        if (ack_seen !== 1'b0 || busy !== 1'b0)
            $display("FAIL to_no_ack: actual ack_seen=%b busy=%b, required 0 0", ack_seen, busy);
        else n_pass++;
        tick();
        e = sb_q.pop_front();
        n_checks++;
        if ({err, tx_start, active_id, tx_data} !== {1'b0, 1'b1, e.id, e.data})
            $display("FAIL to_next_grant: actual err=%b start=%b id=%0d data=%h, required 0 1 %0d %h",
                     err, tx_start, active_id, tx_data, e.id, e.data);
        else n_pass++;
        req = '0;
        wait_idle(40, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL to_idle: actual busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_busy_block();
        exp_t e;
        int   starts;
        model_en = 1'b0;
        man_busy = 1'b1;
        data     = {8'h00, 8'h00, 8'h00, 8'h5A};
        req      = 4'b0001;
        starts   = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_start === 1'b1) starts++;
        end
        n_checks++;
        if (starts !== 0 || busy !== 1'b0)
            $display("FAIL blk_no_grant: actual starts=%0d busy=%b, required 0 0", starts, busy);
        else n_pass++;
        man_busy = 1'b0;
        data     = {8'h00, 8'h00, 8'h00, 8'h3C};
        sb_q.push_back('{id: 2'd0, data: 8'h3C});
        tick();
        n_checks++;
        if (tx_start !== 1'b1) $display("FAIL blk_start: actual %b, required 1", tx_start);
        else n_pass++;
        data     = {8'h00, 8'h00, 8'h00, 8'hFF};
        req      = '0;
        man_busy = 1'b1;
        e = sb_q.pop_front();
        n_checks++;
        if ({active_id, tx_data} !== {e.id, e.data})
            $display("FAIL blk_grant: actual id=%0d data=%h, required id=%0d data=%h",
                     active_id, tx_data, e.id, e.data);
        else n_pass++;
        tick();
        n_checks++;
        if (tx_data !== 8'h3C || tx_start !== 1'b0)
            $display("FAIL blk_hold: actual data=%h start=%b, required 3c 0", tx_data, tx_start);
        else n_pass++;
        tick();
        n_checks++;
        if (ack !== 4'b0001) $display("FAIL blk_ack: actual %b, required 0001", ack);
        else n_pass++;
        man_busy = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL blk_done: actual busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        model_en = 1'b0;
        man_busy = 1'b0;
        data     = {8'h83, 8'h82, 8'h81, 8'h80};
        do_reset();
        // Leave rr pointer at 1, then reset during requester 1's WAIT_DONE.
        req = 4'b0001;
        tick();
        manual_finish();
        req = 4'b0010;
        tick();
        n_checks++;
        if ({tx_start, active_id} !== {1'b1, 2'd1})
            $display("FAIL mid_grant1: actual start=%b id=%0d, required 1 1", tx_start, active_id);
        else n_pass++;
        req      = '0;
        man_busy = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mid_in_frame: actual busy=%b, required 1", busy);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        man_busy = 1'b0;
        n_checks++;
        if ({ack, tx_start, tx_data, active_id, busy, err} !== '0)
            $display("FAIL mid_reset: actual ack=%b start=%b data=%h id=%0d busy=%b err=%b, required all 0",
                     ack, tx_start, tx_data, active_id, busy, err);
        else n_pass++;
        req = 4'b0011;
        sb_q.push_back('{id: 2'd0, data: 8'h80});
        tick();
        e = sb_q.pop_front();
        n_checks++;
        if ({tx_start, active_id, tx_data} !== {1'b1, e.id, e.data})
            $display("FAIL mid_rr_zero: actual start=%b id=%0d data=%h, required 1 %0d %h",
                     tx_start, active_id, tx_data, e.id, e.data);
        else n_pass++;
        manual_finish();
        req = 4'b1000;
        sb_q.push_back('{id: 2'd3, data: 8'h83});
        tick();
        e = sb_q.pop_front();
        n_checks++;
        if ({tx_start, active_id, tx_data} !== {1'b1, e.id, e.data})
            $display("FAIL mid_grant3: actual start=%b id=%0d data=%h, required 1 %0d %h",
                     tx_start, active_id, tx_data, e.id, e.data);
        else n_pass++;
        manual_finish();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        test_reset();
        test_single();
        test_all_rr();
        test_alternate();
        test_timeout();
        test_busy_block();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
